// File: rtl/core_pkg.sv
// core_pkg: shared RV32 core types, control-bit indices and pipeline-register layout
package core_pkg;
  localparam int XLEN = 32;
  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_MEM_READ = 5;
  localparam int CTRL_MEM_WRITE = 4;
  localparam int CTRL_BRANCH = 3;
  localparam int CTRL_ALU_SRC = 2;
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;
  localparam logic [7:0] CTRL_NOP = 8'h00;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      funct;
    logic [7:0]      ctrl;
  } id_ex_t;
  // rd=0 and MemRead=0 keep a bubble invisible to forwarding and hazard logic
  function automatic id_ex_t nop_image();
    id_ex_t n;
    n = '0;
    n.ctrl = CTRL_NOP;
    return n;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with hold, used for pipeline performance reporting
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         hold_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // hold wins over increment; stop at all-ones instead of wrapping
  always_comb cnt_d = (hold_i || !inc_i || &cnt_q) ? cnt_q : cnt_q + 1'b1;
  // count register, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with stall, bubble/flush NOP insertion and perf counters
module id_ex_pipe
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             bubble_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic [3:0]       id_funct_i,
  input  logic [7:0]       id_ctrl_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic [3:0]       ex_funct_o,
  output logic [7:0]       ex_ctrl_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  id_ex_t pipe_q, pipe_d, id_fields;
  assign id_fields = '{valid: 1'b1, pc: id_pc_i, rs1_data: id_rs1_data_i,
                       rs2_data: id_rs2_data_i, imm: id_imm_i, rs1: id_rs1_i,
                       rs2: id_rs2_i, rd: id_rd_i, funct: id_funct_i, ctrl: id_ctrl_i};
  // stall holds, flush or bubble squash to a NOP, otherwise take the ID instruction
  always_comb pipe_d = stall_i ? pipe_q : (flush_i || bubble_i) ? nop_image() : id_fields;
  // pipeline register, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) pipe_q <= '0;
    else pipe_q <= pipe_d;
  // a simultaneous flush and bubble is accounted as a flush only
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(bubble_i && !flush_i), .hold_i(stall_i),
    .cnt_o(bubble_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(flush_i), .hold_i(stall_i),
    .cnt_o(flush_cnt_o)
  );
  assign ex_valid_o    = pipe_q.valid;
  assign ex_pc_o       = pipe_q.pc;
  assign ex_rs1_data_o = pipe_q.rs1_data;
  assign ex_rs2_data_o = pipe_q.rs2_data;
  assign ex_imm_o      = pipe_q.imm;
  assign ex_rs1_o      = pipe_q.rs1;
  assign ex_rs2_o      = pipe_q.rs2;
  assign ex_rd_o       = pipe_q.rd;
  assign ex_funct_o    = pipe_q.funct;
  assign ex_ctrl_o     = pipe_q.ctrl;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: scoreboard bench for the ID/EX pipeline register
module tb_id_ex_pipe;
  import core_pkg::*;
  localparam int CW = 4;
  typedef struct packed {
    id_ex_t        s;
    logic [CW-1:0] b;
    logic [CW-1:0] f;
  } exp_t;
  logic clk_i = 0, rst_i = 0, stall_i = 0, bubble_i = 0, flush_i = 0;
  id_ex_t id_in = '0;
  id_ex_t obs;
  logic ex_valid_o;
  logic [XLEN-1:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [3:0] ex_funct_o;
  logic [7:0] ex_ctrl_o;
  logic [CW-1:0] bubble_cnt_o, flush_cnt_o;
  int checks = 0, errors = 0;
  exp_t sb_q[$];
  id_ex_t m = '0;
  logic [CW-1:0] mb = '0, mf = '0;
  id_ex_t tmp;
  always #5 clk_i = ~clk_i;
  id_ex_pipe #(.CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .bubble_i(bubble_i), .flush_i(flush_i),
    .id_pc_i(id_in.pc), .id_rs1_data_i(id_in.rs1_data), .id_rs2_data_i(id_in.rs2_data),
    .id_imm_i(id_in.imm), .id_rs1_i(id_in.rs1), .id_rs2_i(id_in.rs2), .id_rd_i(id_in.rd),
    .id_funct_i(id_in.funct), .id_ctrl_i(id_in.ctrl),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o),
    .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o), .ex_ctrl_o(ex_ctrl_o),
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
  );
  assign obs = {ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
                ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o, ex_ctrl_o};
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask
  function automatic id_ex_t rand_id();
    id_ex_t r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction
  function automatic id_ex_t mk(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                                input logic [7:0] ctrl);
    id_ex_t r;
    r = rand_id();
    r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.ctrl = ctrl;
    return r;
  endfunction
  task automatic step(input logic st, input logic bu, input logic fl, input id_ex_t id);
    exp_t e;
    @(negedge clk_i);
    stall_i = st; bubble_i = bu; flush_i = fl; id_in = id;
    if (!st) begin
      if (fl) begin m = '0; if (mf != '1) mf = mf + 1'b1; end
      else if (bu) begin m = '0; if (mb != '1) mb = mb + 1'b1; end
      else begin m = id; m.valid = 1'b1; end
    end
    sb_q.push_back('{s: m, b: mb, f: mf});
    @(posedge clk_i); #1;
    e = sb_q.pop_front();
    check("pipe", obs, e.s);
    check("bubble_cnt", bubble_cnt_o, e.b);
    check("flush_cnt", flush_cnt_o, e.f);
  endtask
  task automatic check_reset(input string tag);
    check(tag, obs, '0);
    check({tag, "_bcnt"}, bubble_cnt_o, '0);
    check({tag, "_fcnt"}, flush_cnt_o, '0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); id_in = rand_id(); bubble_i = 1'($urandom); flush_i = 1'($urandom);
      @(posedge clk_i); #1;
      check_reset("reset_hold");
    end
    @(posedge clk_i); #2;
    rst_i = 1;
    step(0, 0, 0, mk(32'h100, 5'd1, 5'd2, 5'd5, 8'h84));
    check("first_pc", ex_pc_o, 32'h100);
    check("first_rd", ex_rd_o, 5);
    check("first_valid", ex_valid_o, 1);
    step(0, 0, 0, mk(32'h104, 5'd2, 5'd0, 5'd5, 8'hE0));
    check("lw_memread", ex_ctrl_o[CTRL_MEM_READ], 1);
    tmp = mk(32'h108, 5'd5, 5'd1, 5'd6, 8'h82);
    step(0, 1, 0, tmp);
    check("bubble_valid", ex_valid_o, 0);
    check("bubble_rd", ex_rd_o, 0);
    check("bubble_ctrl", ex_ctrl_o, 0);
    check("bubble_cnt1", bubble_cnt_o, 1);
    step(0, 0, 0, tmp);
    check("add_rd", ex_rd_o, 6);
    check("add_valid", ex_valid_o, 1);
    for (int i = 0; i < 4; i++) step(1, 1'($urandom), 1'($urandom), rand_id());
    check("stall_pc", ex_pc_o, 32'h108);
    step(0, 0, 1, rand_id());
    check("flush_cnt1", flush_cnt_o, 1);
    step(0, 1, 1, rand_id());
    check("both_fcnt", flush_cnt_o, 2);
    check("both_bcnt", bubble_cnt_o, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, rand_id());
    check("sat_15", bubble_cnt_o, 15);
    step(0, 1, 0, rand_id());
    step(0, 1, 0, rand_id());
    check("sat_hold", bubble_cnt_o, 15);
    for (int i = 0; i < 3; i++) step(0, 0, 0, rand_id());
    @(negedge clk_i); #2;
    rst_i = 0;
    #1;
    check_reset("async_reset");
    m = '0; mb = '0; mf = '0;
    @(posedge clk_i); #1;
    check_reset("async_hold");
    #1 rst_i = 1;
    step(0, 0, 0, rand_id());
    step(0, 0, 1, rand_id());
    step(0, 0, 0, rand_id());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
